// File: rtl/qspi_bus_arbiter_pkg.sv
// Shared types and constants for the two-port QSPI read-burst arbiter.
package qspi_bus_arbiter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DATA,
    S_STOP
  } state_e;

  localparam logic [1:0] TGT_FLASH = 2'd0;
  localparam logic [1:0] TGT_RAM_A = 2'd1;
  localparam logic [1:0] TGT_RAM_B = 2'd2;

  localparam int DEFAULT_STARVE_LIMIT = 4;

  // A length field of zero encodes a full 256-word burst.
  function automatic logic [8:0] burst_words(input logic [7:0] len);
    return {(len == 8'd0), len};
  endfunction

endpackage

// File: rtl/qspi_bus_arbiter_grant.sv
// Port selection: fixed priority to port 0, with port 1 forced through once
// port 0 has won STARVE_LIMIT consecutive grants while port 1 was waiting.
module qspi_grant_select
  import qspi_bus_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_grant,
  output logic o_valid,
  output logic o_port
);

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  logic [2:0] r_starve;
  logic       w_force1;

  assign w_force1 = i_valid1 && (r_starve == LIMIT);
  assign o_valid  = i_valid0 || i_valid1;
  assign o_port   = i_valid1 && (!i_valid0 || w_force1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_starve <= 3'd0;
    end else if (!i_valid1) begin
      r_starve <= 3'd0;
    end else if (i_grant) begin
      if (o_port)
        r_starve <= 3'd0;
      else if (r_starve != LIMIT)
        r_starve <= r_starve + 3'd1;
    end
  end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Two-port read-burst arbiter in front of a shared SPI flash/RAM controller.
// Outputs are combinational from the FSM and forced idle while rst_n is low.
module qspi_bus_arbiter
  import qspi_bus_arbiter_pkg::*;
#(
  parameter int ADDR_BITS    = 24,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_req0_valid,
  input  logic [ADDR_BITS-1:0] i_req0_addr,
  input  logic [1:0]           i_req0_target,
  input  logic [7:0]           i_req0_len,
  input  logic                 i_req0_abort,
  output logic                 o_req0_ready,
  output logic                 o_req0_data_valid,
  output logic [15:0]          o_req0_data,
  output logic                 o_req0_done,
  input  logic                 i_req1_valid,
  input  logic [ADDR_BITS-1:0] i_req1_addr,
  input  logic [1:0]           i_req1_target,
  input  logic [7:0]           i_req1_len,
  input  logic                 i_req1_abort,
  output logic                 o_req1_ready,
  output logic                 o_req1_data_valid,
  output logic [15:0]          o_req1_data,
  output logic                 o_req1_done,
  output logic [ADDR_BITS-1:0] o_ctl_addr,
  output logic                 o_ctl_start,
  output logic                 o_ctl_continue,
  output logic                 o_ctl_stop,
  input  logic [15:0]          i_ctl_data,
  input  logic                 i_ctl_busy,
  input  logic                 i_ctl_select_n,
  output logic                 o_flash_cs_n,
  output logic                 o_ram_a_cs_n,
  output logic                 o_ram_b_cs_n
);

  state_e                 r_state, w_state_next;
  logic [ADDR_BITS-1:0]   r_addr;
  logic [1:0]             r_target;
  logic [8:0]             r_remaining;
  logic                   r_port;
  logic                   r_abort;
  logic                   r_wait_first;
  logic                   r_stop_held;

  logic                   w_sel_valid, w_sel_port;
  logic                   w_grant, w_dv, w_done;
  logic                   w_start, w_cont, w_stop;
  logic                   w_abort_in, w_last, w_bus_owned;
  logic [ADDR_BITS-1:0]   w_sel_addr;

  qspi_grant_select #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid0(i_req0_valid),
    .i_valid1(i_req1_valid),
    .i_grant (w_grant),
    .o_valid (w_sel_valid),
    .o_port  (w_sel_port)
  );

  assign w_sel_addr = w_sel_port ? i_req1_addr : i_req0_addr;
  assign w_abort_in = r_port ? i_req1_abort : i_req0_abort;
  // A word already in DATA is always delivered; abort only picks stop over continue.
  assign w_last     = (r_remaining == 9'd1) || r_abort || w_abort_in;

  always_comb begin
    w_state_next = r_state;
    w_grant      = 1'b0;
    w_dv         = 1'b0;
    w_start      = 1'b0;
    w_cont       = 1'b0;
    w_stop       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_sel_valid) begin
          w_grant      = 1'b1;
          w_state_next = S_START;
        end
      end
      S_START: begin
        w_start      = 1'b1;
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (!r_wait_first && !i_ctl_busy)
          w_state_next = S_DATA;
      end
      S_DATA: begin
        w_dv = 1'b1;
        if (w_last) begin
          w_stop       = 1'b1;
          w_state_next = S_STOP;
        end else begin
          w_cont       = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_STOP: begin
        if (r_stop_held && i_ctl_select_n) begin
          w_done       = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
    if (!rst_n) begin
      w_grant = 1'b0;
      w_dv    = 1'b0;
      w_start = 1'b0;
      w_cont  = 1'b0;
      w_stop  = 1'b0;
      w_done  = 1'b0;
    end
  end

  assign o_req0_ready      = w_grant && !w_sel_port;
  assign o_req1_ready      = w_grant && w_sel_port;
  assign o_req0_data_valid = w_dv && !r_port;
  assign o_req1_data_valid = w_dv && r_port;
  assign o_req0_data       = (w_dv && !r_port) ? i_ctl_data : 16'd0;
  assign o_req1_data       = (w_dv && r_port) ? i_ctl_data : 16'd0;
  assign o_req0_done       = w_done && !r_port;
  assign o_req1_done       = w_done && r_port;
  assign o_ctl_start       = w_start;
  assign o_ctl_continue    = w_cont;
  assign o_ctl_stop        = w_stop;
  assign o_ctl_addr        = rst_n ? r_addr : '0;

  // Reserved target 3 is routed to flash.
  assign w_bus_owned  = rst_n && (r_state != S_IDLE);
  assign o_flash_cs_n = !(w_bus_owned && (r_target == TGT_FLASH || r_target == 2'd3)) || i_ctl_select_n;
  assign o_ram_a_cs_n = !(w_bus_owned && r_target == TGT_RAM_A) || i_ctl_select_n;
  assign o_ram_b_cs_n = !(w_bus_owned && r_target == TGT_RAM_B) || i_ctl_select_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_target     <= TGT_FLASH;
      r_remaining  <= 9'd0;
      r_port       <= 1'b0;
      r_abort      <= 1'b0;
      r_wait_first <= 1'b0;
      r_stop_held  <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_wait_first <= (r_state != S_WAIT);
      r_stop_held  <= (r_state == S_STOP);
      if (w_grant) begin
        r_addr      <= {w_sel_addr[ADDR_BITS-1:1], 1'b0};
        r_target    <= w_sel_port ? i_req1_target : i_req0_target;
        r_remaining <= burst_words(w_sel_port ? i_req1_len : i_req0_len);
        r_port      <= w_sel_port;
        r_abort     <= 1'b0;
      end else if (r_state != S_IDLE && w_abort_in) begin
        r_abort <= 1'b1;
      end
      if (w_dv)
        r_remaining <= r_remaining - 9'd1;
    end
  end

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Directed bench for qspi_bus_arbiter with a behavioural controller and a
// per-cycle transaction-level model of the expected arbiter outputs.
module tb_qspi_bus_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_req0_valid, i_req0_abort, i_req1_valid, i_req1_abort;
  logic [23:0] i_req0_addr, i_req1_addr;
  logic [1:0]  i_req0_target, i_req1_target;
  logic [7:0]  i_req0_len, i_req1_len;
  logic        o_req0_ready, o_req0_data_valid, o_req0_done;
  logic        o_req1_ready, o_req1_data_valid, o_req1_done;
  logic [15:0] o_req0_data, o_req1_data;
  logic [23:0] o_ctl_addr;
  logic        o_ctl_start, o_ctl_continue, o_ctl_stop;
  logic [15:0] i_ctl_data;
  logic        i_ctl_busy, i_ctl_select_n;
  logic        o_flash_cs_n, o_ram_a_cs_n, o_ram_b_cs_n;

  always #5 clk = ~clk;

  qspi_bus_arbiter #(.ADDR_BITS(24), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req0_valid(i_req0_valid), .i_req0_addr(i_req0_addr), .i_req0_target(i_req0_target),
    .i_req0_len(i_req0_len), .i_req0_abort(i_req0_abort), .o_req0_ready(o_req0_ready),
    .o_req0_data_valid(o_req0_data_valid), .o_req0_data(o_req0_data), .o_req0_done(o_req0_done),
    .i_req1_valid(i_req1_valid), .i_req1_addr(i_req1_addr), .i_req1_target(i_req1_target),
    .i_req1_len(i_req1_len), .i_req1_abort(i_req1_abort), .o_req1_ready(o_req1_ready),
    .o_req1_data_valid(o_req1_data_valid), .o_req1_data(o_req1_data), .o_req1_done(o_req1_done),
    .o_ctl_addr(o_ctl_addr), .o_ctl_start(o_ctl_start), .o_ctl_continue(o_ctl_continue),
    .o_ctl_stop(o_ctl_stop), .i_ctl_data(i_ctl_data), .i_ctl_busy(i_ctl_busy),
    .i_ctl_select_n(i_ctl_select_n), .o_flash_cs_n(o_flash_cs_n), .o_ram_a_cs_n(o_ram_a_cs_n),
    .o_ram_b_cs_n(o_ram_b_cs_n)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural SPI controller ----------------
  int          busy_cycles = 0;
  int          sel_hold = 0;
  int          c_busy_cnt, c_sel_cnt, c_idx;
  bit          c_stopping;
  logic [15:0] c_base;
  logic        s_rst, s_start, s_cont, s_stop;
  logic [23:0] s_addr;

  initial begin
    i_ctl_busy = 1'b0; i_ctl_select_n = 1'b1; i_ctl_data = 16'd0;
    c_busy_cnt = 0; c_sel_cnt = 0; c_idx = 0; c_stopping = 0; c_base = 16'd0;
    forever begin
      @(negedge clk);
      s_rst = rst_n; s_start = o_ctl_start; s_cont = o_ctl_continue;
      s_stop = o_ctl_stop; s_addr = o_ctl_addr;
      @(posedge clk); #1;
      if (!s_rst) begin
        c_busy_cnt = 0; c_sel_cnt = 0; c_idx = 0; c_stopping = 0; c_base = 16'd0;
        i_ctl_busy = 1'b0; i_ctl_select_n = 1'b1; i_ctl_data = 16'd0;
      end else begin
        if (c_busy_cnt > 0) c_busy_cnt--;
        if (s_start) begin
          c_base = s_addr[16:1]; c_idx = 0; c_busy_cnt = busy_cycles; i_ctl_select_n = 1'b0;
        end
        if (s_cont) begin
          c_idx++; c_busy_cnt = busy_cycles;
        end
        if (s_stop) begin
          c_stopping = 1; c_sel_cnt = sel_hold;
        end else if (c_stopping && c_sel_cnt > 0) begin
          c_sel_cnt--;
        end
        if (c_stopping && c_sel_cnt == 0) begin
          i_ctl_select_n = 1'b1; c_stopping = 0;
        end
        i_ctl_busy = (c_busy_cnt > 0);
        i_ctl_data = c_base + 16'(c_idx);
      end
    end
  end

  // ---------------- transaction-level model and compare ----------------
  bit          m_active, m_port, m_abort, m_stopped;
  int          m_age, m_since, m_words, m_total, m_starve;
  logic [1:0]  m_tgt;
  logic [23:0] m_addr;
  int          n_start, n_cont, n_stop, n_dv, n_done;
  int          n_flash_low, n_ra_low, n_rb_low;
  int          glog[$];

  task automatic clear_counts();
    n_start = 0; n_cont = 0; n_stop = 0; n_dv = 0; n_done = 0;
    n_flash_low = 0; n_ra_low = 0; n_rb_low = 0;
  endtask

  initial begin
    logic       ev, ep, dv, odv, gdone, odone, last;
    logic [2:0] cs_vec, cs_exp;
    logic [15:0] gdata;
    m_active = 0; m_port = 0; m_abort = 0; m_stopped = 0; m_age = 0; m_since = 0;
    m_words = 0; m_total = 0; m_starve = 0; m_tgt = 2'd0; m_addr = 24'd0;
    clear_counts();
    forever begin
      @(negedge clk);
      cs_vec = {o_ram_b_cs_n, o_ram_a_cs_n, o_flash_cs_n};
      if (!rst_n) begin
        chk("reset_pulses", 32'({o_req0_ready, o_req1_ready, o_req0_data_valid, o_req1_data_valid,
            o_req0_done, o_req1_done, o_ctl_start, o_ctl_continue, o_ctl_stop}), 32'd0);
        chk("reset_cs", 32'(cs_vec), 32'h7);
        chk("reset_addr_data", {8'(o_ctl_addr), o_req0_data | o_req1_data}, 32'd0);
        m_active = 0; m_stopped = 0; m_starve = 0;
      end else begin
        ev = !m_active && (i_req0_valid || i_req1_valid);
        ep = i_req1_valid && (!i_req0_valid || m_starve == LIM);
        chk("ready0", 32'(o_req0_ready), 32'(ev && !ep));
        chk("ready1", 32'(o_req1_ready), 32'(ev && ep));
        if (m_active) begin
          dv    = m_port ? o_req1_data_valid : o_req0_data_valid;
          odv   = m_port ? o_req0_data_valid : o_req1_data_valid;
          gdone = m_port ? o_req1_done : o_req0_done;
          odone = m_port ? o_req0_done : o_req1_done;
          gdata = m_port ? o_req1_data : o_req0_data;
          chk("other_port", 32'({odv, odone}), 32'd0);
          if (m_port ? i_req1_abort : i_req0_abort) m_abort = 1;
          chk("ctl_start", 32'(o_ctl_start), 32'(m_age == 1));
          if (m_age == 1) chk("ctl_addr", 32'(o_ctl_addr[23:1]), 32'(m_addr[23:1]));
          if (dv) begin
            last = m_abort || (m_words + 1 == m_total);
            chk("word_after_stop", 32'(m_stopped), 32'd0);
            chk("data", 32'(gdata), 32'(m_addr[16:1] + 16'(m_words)));
            chk("ctl_stop", 32'(o_ctl_stop), 32'(last));
            chk("ctl_continue", 32'(o_ctl_continue), 32'(!last));
            m_words++;
            if (last) begin m_stopped = 1; m_since = 0; end
          end else begin
            chk("cmd_without_word", 32'({o_ctl_continue, o_ctl_stop}), 32'd0);
          end
          chk("done", 32'(gdone), 32'(m_stopped && m_since >= 2 && i_ctl_select_n));
          cs_exp = 3'b111;
          cs_exp[(m_tgt == 2'd1) ? 1 : (m_tgt == 2'd2) ? 2 : 0] = i_ctl_select_n;
          chk("cs_busy", 32'(cs_vec), 32'(cs_exp));
          if (gdone) m_active = 0;
        end else begin
          chk("idle_pulses", 32'({o_req0_data_valid, o_req1_data_valid, o_req0_done, o_req1_done,
              o_ctl_start, o_ctl_continue, o_ctl_stop}), 32'd0);
          chk("cs_idle", 32'(cs_vec), 32'h7);
        end
        n_start += int'(o_ctl_start); n_cont += int'(o_ctl_continue); n_stop += int'(o_ctl_stop);
        n_dv += int'(o_req0_data_valid) + int'(o_req1_data_valid);
        n_done += int'(o_req0_done) + int'(o_req1_done);
        n_flash_low += int'(!o_flash_cs_n); n_ra_low += int'(!o_ram_a_cs_n); n_rb_low += int'(!o_ram_b_cs_n);
        if (m_active) m_age++;
        if (m_stopped) m_since++;
        if (!i_req1_valid) m_starve = 0;
        else if (ev && ep) m_starve = 0;
        else if (ev && m_starve < LIM) m_starve++;
        if (ev) begin
          glog.push_back(int'(ep));
          m_active = 1; m_port = ep; m_age = 1; m_words = 0; m_abort = 0; m_stopped = 0;
          m_tgt  = ep ? i_req1_target : i_req0_target;
          m_addr = ep ? i_req1_addr : i_req0_addr;
          m_total = ((ep ? i_req1_len : i_req0_len) == 8'd0) ? 256 : int'(ep ? i_req1_len : i_req0_len);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input int p, input logic v, input logic [23:0] a,
                       input logic [1:0] t, input logic [7:0] l);
    if (p == 0) begin
      i_req0_valid = v; i_req0_addr = a; i_req0_target = t; i_req0_len = l;
    end else begin
      i_req1_valid = v; i_req1_addr = a; i_req1_target = t; i_req1_len = l;
    end
  endtask

  task automatic wait_pulse(input string name, input int p, input bit is_done, input int maxc);
    int n; bit got;
    got = 0; n = 0;
    while (!got && n < maxc) begin
      @(negedge clk); n++;
      if (is_done) got = (p == 0) ? o_req0_done : o_req1_done;
      else         got = (p == 0) ? o_req0_ready : o_req1_ready;
    end
    chk(name, 32'(got), 32'd1);
  endtask

  task automatic run_burst(input int p, input logic [23:0] a, input logic [1:0] t,
                           input logic [7:0] l, input int maxc);
    drive(p, 1'b1, a, t, l);
    wait_pulse("ready_seen", p, 0, maxc);
    @(posedge clk); #1;
    drive(p, 1'b0, a, t, l);
    wait_pulse("done_seen", p, 1, maxc);
    @(posedge clk); #1;
  endtask

  initial begin
    int ks, kd, kr, k;
    int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    i_req0_valid = 0; i_req0_addr = 0; i_req0_target = 0; i_req0_len = 0; i_req0_abort = 0;
    i_req1_valid = 0; i_req1_addr = 0; i_req1_target = 0; i_req1_len = 0; i_req1_abort = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cs_literal", 32'({o_ram_b_cs_n, o_ram_a_cs_n, o_flash_cs_n}), 32'h7);
    @(posedge clk); #1; rst_n = 1'b1;

    // Port 0 alone, 3 words, controller busy 4 cycles per word.
    busy_cycles = 4; sel_hold = 0; clear_counts();
    run_burst(0, 24'h000100, 2'd0, 8'd3, 200);
    $display("burst p0 len3: start=%0d cont=%0d stop=%0d words=%0d done=%0d", n_start, n_cont, n_stop, n_dv, n_done);
    chk("t1_start", n_start, 1); chk("t1_cont", n_cont, 2); chk("t1_stop", n_stop, 1);
    chk("t1_words", n_dv, 3); chk("t1_done", n_done, 1);
    chk("t1_flash_low", 32'(n_flash_low != 0), 1); chk("t1_ram_low", n_ra_low + n_rb_low, 0);

    // Both ports requesting continuously: starvation override every fifth grant.
    busy_cycles = 0; clear_counts(); glog.delete();
    drive(0, 1'b1, 24'h000400, 2'd1, 8'd1);
    drive(1, 1'b1, 24'h000800, 2'd2, 8'd1);
    k = 0;
    while (glog.size() < 10 && k < 1000) begin @(posedge clk); #1; k++; end
    drive(0, 1'b0, 24'h000400, 2'd1, 8'd1);
    drive(1, 1'b0, 24'h000800, 2'd2, 8'd1);
    k = 0;
    while (n_done < 10 && k < 200) begin @(posedge clk); #1; k++; end
    chk("t2_grants", glog.size(), 10); chk("t2_done", n_done, 10);
    for (int i = 0; i < 10 && i < glog.size(); i++) begin
      $display("grant %0d -> port %0d", i, glog[i]);
      chk("t2_grant_seq", glog[i], exp_seq[i]);
    end

    // Port 1, RAM B, len 0 means 256 words; odd address bit must be ignored.
    clear_counts();
    run_burst(1, 24'h123457, 2'd2, 8'd0, 5000);
    $display("burst p1 len0: words=%0d done=%0d", n_dv, n_done);
    chk("t3_words", n_dv, 256); chk("t3_done", n_done, 1);
    chk("t3_other_cs", n_flash_low + n_ra_low, 0); chk("t3_ramb_low", 32'(n_rb_low != 0), 1);

    // Abort raised in the second WAIT of a 10-word burst.
    busy_cycles = 2; clear_counts();
    fork
      run_burst(0, 24'h00ABCD, 2'd1, 8'd10, 500);
      begin
        k = 0;
        while (n_dv < 1 && k < 200) begin @(posedge clk); #1; k++; end
        i_req0_abort = 1'b1;
        @(posedge clk); #1;
        i_req0_abort = 1'b0;
      end
    join
    $display("burst p0 abort: words=%0d stop=%0d done=%0d", n_dv, n_stop, n_done);
    chk("t4_words", n_dv, 2); chk("t4_stop", n_stop, 1); chk("t4_cont", n_cont, 1);
    chk("t4_done", n_done, 1);

    // Reset asserted for one cycle in a DATA cycle of a running burst.
    busy_cycles = 0; clear_counts();
    drive(0, 1'b1, 24'h000200, 2'd0, 8'd8);
    wait_pulse("t5_ready", 0, 0, 50);
    @(posedge clk); #1; drive(0, 1'b0, 24'h000200, 2'd0, 8'd8);
    k = 0;
    while (!o_req0_data_valid && k < 50) begin @(negedge clk); k++; end
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    chk("t5_cs_after_reset", 32'({o_ram_b_cs_n, o_ram_a_cs_n, o_flash_cs_n}), 32'h7);
    chk("t5_no_done", n_done + int'(o_req0_done), 0);
    $display("reset mid-burst: words before reset=%0d done=%0d", n_dv, n_done);
    @(posedge clk); #1; clear_counts();
    run_burst(1, 24'h000040, 2'd1, 8'd2, 200);
    chk("t5_new_words", n_dv, 2); chk("t5_new_done", n_done, 1);

    // Select held low 5 cycles after stop: done waits, port 1 waits for the idle cycle.
    sel_hold = 5; clear_counts();
    drive(0, 1'b1, 24'h000300, 2'd0, 8'd1);
    wait_pulse("t6_ready", 0, 0, 50);
    @(posedge clk); #1;
    drive(0, 1'b0, 24'h000300, 2'd0, 8'd1);
    drive(1, 1'b1, 24'h000500, 2'd2, 8'd1);
    k = 0; ks = -100; kd = -100; kr = -100;
    while (kr < 0 && k < 100) begin
      @(negedge clk); k++;
      if (o_ctl_stop && ks < 0) ks = k;
      if (o_req0_done) kd = k;
      if (o_req1_ready) kr = k;
    end
    $display("select hold: stop@%0d done@%0d next grant@%0d", ks, kd, kr);
    chk("t6_done_gap", 32'(kd - ks), 32'd6); chk("t6_regrant_gap", 32'(kr - kd), 32'd1);
    @(posedge clk); #1; drive(1, 1'b0, 24'h000500, 2'd2, 8'd1);
    wait_pulse("t6_done1", 1, 1, 100);
    sel_hold = 0;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/qspi_bus_arbiter.md
QSPI_BUS_ARBITER -- requirements
Module: qspi_bus_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_BITS, default 24, byte address width; STARVE_LIMIT, default 4, consecutive port-0 grants tolerated while port 1 waits.
REQ-002 clk  in  1  clock; all logic SHALL be on the rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 reqN_valid  in  1  port N (N=0 video, N=1 aux) requests a read burst; SHALL be held until reqN_ready.
REQ-005 reqN_addr  in  ADDR_BITS  burst start byte address, bit 0 ignored (halfword aligned).
REQ-006 reqN_target  in  2  device: 0 flash, 1 RAM A, 2 RAM B, 3 reserved (treated as flash).
REQ-007 reqN_len  in  8  burst length in 16-bit words, 0 means 256.
REQ-008 reqN_abort  in  1  terminate the granted burst early.
REQ-009 reqN_ready  out  1  one-cycle pulse: request accepted.
REQ-010 reqN_data_valid  out  1  one-cycle pulse per word; reqN_data  out  16  the word.
REQ-011 reqN_done  out  1  one-cycle pulse when the burst ends, normally or by abort.
REQ-012 ctl_addr  out  ADDR_BITS; ctl_start, ctl_continue, ctl_stop  out  1 each: SPI flash controller command pulses.
REQ-013 ctl_data  in  16; ctl_busy  in  1; ctl_select_n  in  1: controller data word, busy flag, active-low select.
REQ-014 flash_cs_n, ram_a_cs_n, ram_b_cs_n  out  1 each: per-device active-low chip selects.

Function
REQ-015 States SHALL be IDLE, START, WAIT, DATA, STOP.
REQ-016 IDLE: if any valid, grant one, pulse its ready, latch addr/target/len/port, go to START.
REQ-017 Arbitration SHALL be fixed priority to port 0, except port 1 SHALL win when starve count equals STARVE_LIMIT.
REQ-018 Starve count (3 bits) SHALL increment on each port-0 grant with req1_valid high, clear on port-1 grant or when req1_valid low, and saturate at STARVE_LIMIT.
REQ-019 START: ctl_start pulses one cycle with ctl_addr = latched addr; go to WAIT.
REQ-020 WAIT: the first cycle SHALL ignore ctl_busy; thereafter ctl_busy low moves to DATA.
REQ-021 DATA: the granted port's data_valid pulses with ctl_data; remaining count decrements.
REQ-022 DATA: if remaining becomes 0 or abort is seen, ctl_stop pulses and state goes to STOP; otherwise ctl_continue pulses and state returns to WAIT.
REQ-023 abort SHALL be sampled in every non-IDLE state and remembered until DATA or STOP; words already in flight SHALL still be delivered exactly once.
REQ-024 STOP SHALL last 2 cycles minimum and until ctl_select_n is high; then done pulses and state goes to IDLE.
REQ-025 The next grant SHALL NOT be made in the cycle done pulses; minimum inter-burst gap is 1 IDLE cycle.
REQ-026 Chip select: latched target's cs_n = ctl_select_n; other cs_n = 1; all cs_n = 1 in IDLE.
REQ-027 Target SHALL NOT change while any cs_n is low.
REQ-028 data_valid, ready and done SHALL only go to the granted port; the other port's outputs stay 0.
REQ-029 ctl_start, ctl_continue and ctl_stop SHALL be mutually exclusive and single-cycle.
REQ-030 Simultaneous valid on both ports with starve count below the limit: port 0 wins; reqN_len=0 gives exactly 256 data_valid pulses.

Reset
REQ-031 While rst_n is low: state IDLE, starve count 0, all pulses 0, all cs_n 1, ctl_addr 0, reqN_data 0.
REQ-032 Reset mid-burst SHALL abandon the burst with no done pulse; the controller is reset by the same rst_n.

Structure
REQ-033 A shared package SHALL hold the state enum, the target encoding constants (FLASH=0, RAM_A=1, RAM_B=2) and the default STARVE_LIMIT.
REQ-034 One sub-module, qspi_grant_select, SHALL hold the priority and starvation logic; the rest is a single FSM.

Verification
REQ-035 Port 0 alone, addr 0x000100, len 3, controller busy 4 cycles per word: one ctl_start, then exactly 2 continue, 1 stop, 3 data_valid, then done; flash_cs_n follows select.
REQ-036 Both ports valid continuously, STARVE_LIMIT 4: grant sequence 0,0,0,0,1,0,0,0,0,1.
REQ-037 Port 1 target RAM B, len 0: exactly 256 words; only ram_b_cs_n ever low.
REQ-038 req0_abort asserted during the 2nd WAIT of a len-10 burst: exactly 2 data_valid, ctl_stop after the 2nd, then done.
REQ-039 rst_n low for 1 cycle mid-DATA: next cycle all cs_n 1 and state IDLE, no done; a new request completes normally.
REQ-040 ctl_select_n held low 5 cycles after stop: done delayed until select high, no grant in between.
